// File: rtl/mont_pkg.sv
// Shared constants and helpers for the Montgomery multiplier.
package mont_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_ITER = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Accumulator width: t < 2m and the pre-shift sum stays below 2^(WIDTH+D+1).
    function automatic int mont_acc_width(input int width, input int digit_bits);
        return width + digit_bits + 1;
    endfunction

    // (-m^-1) mod 2^D for an odd modulus, from its low two bits.
    function automatic logic [1:0] mont_neg_inv(input logic [1:0] m_low, input int digit_bits);
        logic [1:0] inv;
        if (digit_bits == 1) begin
            inv = 2'd1;
        end else begin
            case (m_low)
                2'b01:   inv = 2'd3;
                2'b11:   inv = 2'd1;
                default: inv = 2'd1;
            endcase
        end
        return inv;
    endfunction

endpackage

// File: rtl/mont_mul_pipe_step.sv
// One Montgomery digit step: t_next = (t + d*a + q*m) >> D.
module mont_step
    import mont_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int DIGIT_BITS = 1,
    localparam int ACC_W = mont_acc_width(WIDTH, DIGIT_BITS)
) (
    input  logic [ACC_W-1:0]      t,
    input  logic [DIGIT_BITS-1:0] d,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH+1:0]      a3,
    input  logic [WIDTH-1:0]      m,
    input  logic [WIDTH+1:0]      m3,
    input  logic [1:0]            mneg,
    output logic [ACC_W-1:0]      t_next
);

    logic [1:0]       d_sel;
    logic [1:0]       q_raw;
    logic [1:0]       q_sel;
    logic [ACC_W-1:0] da;
    logic [ACC_W-1:0] qm;
    logic [ACC_W-1:0] u;
    logic [ACC_W-1:0] s;

    // Widen the digit to two bits so one multiple-select serves both radices.
    if (DIGIT_BITS == 1) begin : g_r2
        assign d_sel = {1'b0, d};
    end else begin : g_r4
        assign d_sel = d;
    end

    // Pick d*a from the precomputed multiples.
    always_comb begin
        da = '0;
        case (d_sel)
            2'd0:    da = '0;
            2'd1:    da = ACC_W'(a);
            2'd2:    da = ACC_W'({a, 1'b0});
            default: da = ACC_W'(a3);
        endcase
    end

    assign u     = t + da;
    assign q_raw = u[1:0] * mneg;
    assign q_sel = (DIGIT_BITS == 1) ? {1'b0, q_raw[0]} : q_raw;

    // Pick q*m so the low D bits of the sum cancel to zero.
    always_comb begin
        qm = '0;
        case (q_sel)
            2'd0:    qm = '0;
            2'd1:    qm = ACC_W'(m);
            2'd2:    qm = ACC_W'({m, 1'b0});
            default: qm = ACC_W'(m3);
        endcase
    end

    assign s      = u + qm;
    assign t_next = s >> DIGIT_BITS;

endmodule

// File: rtl/mont_mul_pipe.sv
// Montgomery modular multiplier: out_result = a*b*2^-WIDTH mod m, D bits of b per cycle.
//
// state   | meaning
// IDLE    | waiting for a job, in_ready high
// LOAD    | precompute 3a/3m, clear t, arm digit counter, reject even m
// ITER    | one digit of b per cycle until the counter expires
// FIX     | final conditional subtract (or force 0 for a rejected job)
// DONE    | result held with out_valid until out_ready
module mont_mul_pipe
    import mont_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int DIGIT_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err,
    output logic             busy
);

    localparam int ACC_W = mont_acc_width(WIDTH, DIGIT_BITS);
    localparam int N_DIG = WIDTH / DIGIT_BITS;
    localparam int CNT_W = $clog2(N_DIG + 1);

    if (!(DIGIT_BITS == 1 || DIGIT_BITS == 2) || (WIDTH % DIGIT_BITS) != 0) begin : g_param_check
        $error("mont_mul_pipe: DIGIT_BITS must be 1 or 2 and divide WIDTH");
    end

    logic [2:0]       state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH+1:0] a3_r;
    logic [WIDTH+1:0] m3_r;
    logic [ACC_W-1:0] t_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] result_r;
    logic             err_r;
    logic [1:0]       mneg;
    logic [ACC_W-1:0] t_next;

    assign mneg = mont_neg_inv(m_r[1:0], DIGIT_BITS);

    mont_step #(
        .WIDTH      (WIDTH),
        .DIGIT_BITS (DIGIT_BITS)
    ) u_step (
        .t      (t_r),
        .d      (b_r[DIGIT_BITS-1:0]),
        .a      (a_r),
        .a3     (a3_r),
        .m      (m_r),
        .m3     (m3_r),
        .mneg   (mneg),
        .t_next (t_next)
    );

    // Sequencer and datapath registers. An even modulus still passes through
    // FIX so rejected jobs report after the same two-cycle minimum.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            m_r      <= '0;
            a3_r     <= '0;
            m3_r     <= '0;
            t_r      <= '0;
            cnt_r    <= '0;
            result_r <= '0;
            err_r    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r      <= in_a;
                        b_r      <= in_b;
                        m_r      <= in_m;
                        result_r <= '0;
                        err_r    <= 1'b0;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    a3_r  <= {1'b0, a_r, 1'b0} + {2'b00, a_r};
                    m3_r  <= {1'b0, m_r, 1'b0} + {2'b00, m_r};
                    t_r   <= '0;
                    cnt_r <= CNT_W'(N_DIG);
                    if (!m_r[0]) begin
                        err_r <= 1'b1;
                        state <= ST_FIX;
                    end else begin
                        state <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    t_r   <= t_next;
                    b_r   <= b_r >> DIGIT_BITS;
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (err_r) begin
                        result_r <= '0;
                    end else if (t_r >= ACC_W'(m_r)) begin
                        result_r <= WIDTH'(t_r - ACC_W'(m_r));
                    end else begin
                        result_r <= WIDTH'(t_r);
                    end
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign out_valid  = (state == ST_DONE);
    assign out_result = result_r;
    assign out_err    = err_r;

endmodule

// File: tb/tb_mont_mul_pipe.sv
// Directed and randomised checks of mont_mul_pipe at 8 and 256 bits, radix 2 and 4.
module tb_mont_mul_pipe;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   in_valid_v;
    logic         out_ready;
    logic [255:0] in_a, in_b, in_m;
    logic [3:0]   in_ready_v, out_valid_v, err_v, busy_v;
    logic [255:0] res_v [4];
    logic [7:0]   r0, r1;
    logic [255:0] r2, r3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // sel 0: W8 D1, sel 1: W8 D2, sel 2: W256 D1, sel 3: W256 D2
    mont_mul_pipe #(.WIDTH(8), .DIGIT_BITS(1)) u_w8d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_m(in_m[7:0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_result(r0),
        .out_err(err_v[0]), .busy(busy_v[0]));

    mont_mul_pipe #(.WIDTH(8), .DIGIT_BITS(2)) u_w8d2 (
        .clk(clk), .reset(reset), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_m(in_m[7:0]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_result(r1),
        .out_err(err_v[1]), .busy(busy_v[1]));

    mont_mul_pipe #(.WIDTH(256), .DIGIT_BITS(1)) u_w256d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_a(in_a), .in_b(in_b), .in_m(in_m),
        .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_result(r2),
        .out_err(err_v[2]), .busy(busy_v[2]));

    mont_mul_pipe #(.WIDTH(256), .DIGIT_BITS(2)) u_w256d2 (
        .clk(clk), .reset(reset), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .in_a(in_a), .in_b(in_b), .in_m(in_m),
        .out_valid(out_valid_v[3]), .out_ready(out_ready), .out_result(r3),
        .out_err(err_v[3]), .busy(busy_v[3]));

    assign res_v[0] = {248'd0, r0};
    assign res_v[1] = {248'd0, r1};
    assign res_v[2] = r2;
    assign res_v[3] = r3;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Submit one job to DUT sel, wait for its result, consume it.
    task automatic run_job(input int sel, input logic [255:0] a, input logic [255:0] b,
                           input logic [255:0] m, output logic [255:0] res,
                           output logic err, output int lat);
        int w = 0;
        while (!in_ready_v[sel] && w < 20) begin
            @(posedge clk); #1; w++;
        end
        in_a = a; in_b = b; in_m = m;
        in_valid_v[sel] = 1'b1;
        @(posedge clk); #1;
        in_valid_v = '0;
        lat = 0;
        while (!out_valid_v[sel] && lat < 1000) begin
            @(posedge clk); #1; lat++;
        end
        chk("job_done_in_time", 256'(lat < 1000), 256'd1);
        res = res_v[sel];
        err = err_v[sel];
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Check a 256-bit result through the defining congruence res*2^256 == a*b (mod m).
    task automatic chk256(input string tag, input logic [255:0] a, input logic [255:0] b,
                          input logic [255:0] m, input logic [255:0] res);
        logic [511:0] lhs, rhs;
        lhs = {res, 256'd0} % {256'd0, m};
        rhs = ({256'd0, a} * {256'd0, b}) % {256'd0, m};
        chk({tag, "_congr"}, lhs[255:0], rhs[255:0]);
        chk({tag, "_lt_m"}, 256'(res < m), 256'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] res, m, a, b, mspec;
        logic         err;
        int           lat, seen;

        reset = 1'b1; in_valid_v = '0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_m = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            chk("rst_in_ready", 256'(in_ready_v[s]), 256'd1);
            chk("rst_out_valid", 256'(out_valid_v[s]), 256'd0);
            chk("rst_busy", 256'(busy_v[s]), 256'd0);
            chk("rst_result", res_v[s], 256'd0);
            chk("rst_err", 256'(err_v[s]), 256'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // radix-2, 8 bit
        run_job(0, 5, 7, 13, res, err, lat);
        chk("w8d1_5x7", res, 1); chk("w8d1_5x7_err", 256'(err), 0); chk("w8d1_lat", 256'(lat), 10);
        run_job(0, 12, 12, 13, res, err, lat);
        chk("w8d1_12x12", res, 3);
        run_job(0, 254, 254, 255, res, err, lat);
        chk("w8d1_m255", res, 1);
        run_job(0, 0, 0, 1, res, err, lat);
        chk("w8d1_m1", res, 0);

        // radix-4, 8 bit
        run_job(1, 12, 12, 13, res, err, lat);
        chk("w8d2_12x12", res, 3); chk("w8d2_err", 256'(err), 0); chk("w8d2_lat", 256'(lat), 6);
        run_job(1, 0, 9, 13, res, err, lat);
        chk("w8d2_a0", res, 0);
        run_job(1, 254, 254, 255, res, err, lat);
        chk("w8d2_m255", res, 1);
        run_job(1, 5, 7, 13, res, err, lat);
        chk("w8d2_5x7", res, 1);
        run_job(1, 0, 0, 1, res, err, lat);
        chk("w8d2_m1", res, 0);

        // even modulus
        run_job(0, 3, 5, 12, res, err, lat);
        chk("even_d1_err", 256'(err), 1); chk("even_d1_res", res, 0); chk("even_d1_lat", 256'(lat), 2);
        run_job(1, 3, 5, 12, res, err, lat);
        chk("even_d2_err", 256'(err), 1); chk("even_d2_res", res, 0); chk("even_d2_lat", 256'(lat), 2);

        // consumer stall in DONE
        in_a = 5; in_b = 7; in_m = 13; in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v = '0;
        seen = 0;
        while (!out_valid_v[0] && seen < 100) begin
            @(posedge clk); #1; seen++;
        end
        for (int i = 0; i < 5; i++) begin
            in_a = 1; in_b = 1; in_m = 11; in_valid_v[0] = 1'b1;
            @(posedge clk); #1;
            chk("hold_valid", 256'(out_valid_v[0]), 1);
            chk("hold_result", res_v[0], 1);
            chk("hold_in_ready", 256'(in_ready_v[0]), 0);
        end
        in_valid_v = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_in_ready", 256'(in_ready_v[0]), 1);
        chk("release_out_valid", 256'(out_valid_v[0]), 0);
        @(posedge clk); #1;
        chk("release_no_job", 256'(busy_v[0]), 0);

        // reset in the middle of ITER
        in_a = 5; in_b = 7; in_m = 13; in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v = '0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("midjob_busy", 256'(busy_v[0]), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_in_ready", 256'(in_ready_v[0]), 1);
        chk("midrst_busy", 256'(busy_v[0]), 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid_v[0]) seen++;
            @(posedge clk); #1;
        end
        chk("midrst_no_valid", 256'(seen), 0);
        run_job(0, 5, 7, 13, res, err, lat);
        chk("after_rst_result", res, 1);

        // 256-bit, large modulus near 2^256
        mspec = '1;
        mspec = mspec - 256'd188;
        a = mspec - 256'd1;
        b = mspec - 256'd2;
        run_job(2, a, b, mspec, res, err, lat);
        chk256("w256d1_big", a, b, mspec, res);
        chk("w256d1_lat", 256'(lat), 258);
        run_job(3, a, b, mspec, res, err, lat);
        chk256("w256d2_big", a, b, mspec, res);
        chk("w256d2_lat", 256'(lat), 130);

        // 256-bit random odd moduli
        for (int n = 0; n < 200; n++) begin
            for (int k = 0; k < 8; k++) begin
                m[k*32 +: 32] = $urandom;
                a[k*32 +: 32] = $urandom;
                b[k*32 +: 32] = $urandom;
            end
            m[0] = 1'b1;
            if (n % 10 == 0) m[255] = 1'b1;
            a = a % m;
            b = b % m;
            run_job((n < 100) ? 2 : 3, a, b, m, res, err, lat);
            chk256((n < 100) ? "w256d1_rand" : "w256d2_rand", a, b, m, res);
            chk("w256_rand_err", 256'(err), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
